// File: rtl/melody_seq.sv
// melody_seq - note-table sequencer driving one square-wave tone channel.
//
// Reads {dur[3:0], div[DW-1:0]} words from an external synchronous ROM that
// has one cycle of read latency. Each note is held for dur*UNIT cycles. The
// output toggles every div cycles, so its period is 2*div cycles; div=0 is a
// rest. dur=0 marks the end of the table, and so does running past the last
// address. At the end the sequencer either stops and pulses done, or
// restarts from address 0 when loop is high.
//
// Build option: define MELODY_SEQ_GAP_EN to insert GAP silent cycles after
// each note that is followed by another fetch.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active high
//   start     play request, sampled only while idle
//   stop      synchronous abort, honoured in every state, wins over start
//   loop      restart at address 0 at the end of the table
//   rom_addr  registered ROM address
//   rom_data  ROM read data {dur, div}, valid one cycle after rom_addr
//   busy      high in every state except IDLE
//   done      one-cycle pulse at the natural end of a song
//   ch_out    tone output
module melody_seq #(
  parameter int AW   = 4,
  parameter int DW   = 16,
  parameter int UNIT = 3000000,
  parameter int GAP  = 600000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [AW-1:0] rom_addr,
  input  logic [DW+3:0] rom_data,
  output logic          busy,
  output logic          done,
  output logic          ch_out
);

  // state    | meaning
  // ---------+---------------------------------------------------
  // ST_IDLE  | waiting for start, outputs quiet
  // ST_FETCH | rom_addr is stable, waiting for the ROM latency
  // ST_LOAD  | rom_data is valid: latch the note or handle the end marker
  // ST_PLAY  | tone (or rest) for dur*UNIT cycles
  // ST_GAP   | silence between notes (only with MELODY_SEQ_GAP_EN)
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_t;

  localparam int DUR_W = $clog2(15 * UNIT + 1);

  state_t             state_q;
  state_t             state_d;
  logic [DUR_W-1:0]   dur_cnt;
  logic [DW-1:0]      div_q;
  logic [DW-1:0]      phase;
  logic [3:0]         rom_dur;
  logic               play_end;
  logic               table_last;
  logic               end_evt;

`ifdef MELODY_SEQ_GAP_EN
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
  logic [GAP_W-1:0]   gap_cnt;
`else
  // GAP only matters when the gap option is built in.
  logic               unused_gap;
  assign unused_gap = (GAP != 0);
`endif

  assign rom_dur    = rom_data[DW+3:DW];
  assign play_end   = (state_q == ST_PLAY) && (dur_cnt == '0);
  assign table_last = (rom_addr == {AW{1'b1}});
  assign busy       = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    end_evt = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        if (rom_dur == 4'd0) begin
          end_evt = 1'b1;
          state_d = loop ? ST_FETCH : ST_IDLE;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (play_end) begin
          // Running off the last address ends the table, with no gap.
          if (table_last) begin
            end_evt = 1'b1;
            state_d = loop ? ST_FETCH : ST_IDLE;
          end else begin
`ifdef MELODY_SEQ_GAP_EN
            state_d = ST_GAP;
`else
            state_d = ST_FETCH;
`endif
          end
        end
      end
`ifdef MELODY_SEQ_GAP_EN
      ST_GAP:   if (gap_cnt == '0) state_d = ST_FETCH;
`endif
      default:  state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d = ST_IDLE;
      end_evt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      done     <= 1'b0;
      ch_out   <= 1'b0;
      dur_cnt  <= '0;
      div_q    <= '0;
      phase    <= '0;
`ifdef MELODY_SEQ_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      done <= end_evt && !loop;

      // The address increment wraps naturally from the last entry to 0.
      if (state_d == ST_IDLE)
        rom_addr <= '0;
      else if ((state_q == ST_LOAD) && end_evt)
        rom_addr <= '0;
      else if (play_end)
        rom_addr <= rom_addr + AW'(1);

      if ((state_q == ST_LOAD) && (rom_dur != 4'd0)) begin
        dur_cnt <= DUR_W'(rom_dur) * DUR_W'(UNIT) - DUR_W'(1);
        div_q   <= rom_data[DW-1:0];
      end else if ((state_q == ST_PLAY) && !play_end) begin
        dur_cnt <= dur_cnt - DUR_W'(1);
      end

      // The tone runs only while staying in PLAY. Entering or leaving PLAY
      // clears the phase and forces the output low.
      if ((state_q == ST_PLAY) && (state_d == ST_PLAY)) begin
        if (div_q == '0) begin
          ch_out <= 1'b0;
          phase  <= '0;
        end else if (phase == div_q - DW'(1)) begin
          ch_out <= ~ch_out;
          phase  <= '0;
        end else begin
          phase  <= phase + DW'(1);
        end
      end else begin
        ch_out <= 1'b0;
        phase  <= '0;
      end

`ifdef MELODY_SEQ_GAP_EN
      if ((state_q == ST_PLAY) && (state_d == ST_GAP))
        gap_cnt <= GAP_W'(GAP - 1);
      else if ((state_q == ST_GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - GAP_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq - directed bench for melody_seq with AW=2, DW=4, UNIT=10 and
// GAP=3, connected to a ROM model with one cycle of read latency. It honours
// MELODY_SEQ_GAP_EN in the same way as the design.
module tb_melody_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       loop;
  logic [1:0] rom_addr;
  logic [7:0] rom_data;
  logic       busy;
  logic       done;
  logic       ch_out;

  logic [7:0] mem [4];

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int d0;

  melody_seq #(.AW(2), .DW(4), .UNIT(10), .GAP(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .ch_out   (ch_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called with the FETCH cycle being sampled; returns in the first PLAY
  // cycle, or in the cycle after LOAD if the entry is an end marker.
  task automatic fetch_load(input int addr);
    chk("fetch_addr", 32'(rom_addr), 32'(addr));
    chk("fetch_busy", 32'(busy), 1);
    chk("fetch_ch", 32'(ch_out), 0);
    step();
    chk("load_busy", 32'(busy), 1);
    chk("load_ch", 32'(ch_out), 0);
    step();
  endtask

  task automatic play(input int n, input int dv);
    for (int k = 0; k < n; k++) begin
      chk("play_ch", 32'(ch_out), (dv == 0) ? 0 : 32'((k / dv) % 2));
      chk("play_busy", 32'(busy), 1);
      step();
    end
  endtask

  task automatic gap();
`ifdef MELODY_SEQ_GAP_EN
    for (int k = 0; k < 3; k++) begin
      chk("gap_ch", 32'(ch_out), 0);
      chk("gap_busy", 32'(busy), 1);
      step();
    end
`endif
  endtask

  task automatic end_done();
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_addr", 32'(rom_addr), 0);
    chk("end_ch", 32'(ch_out), 0);
    step();
    chk("done_pulse_width", 32'(done), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    mem[0] = 8'h14; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h00;
    step(); step();
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ch", 32'(ch_out), 0);
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Two notes followed by an end marker, no loop.
    d0 = done_cnt;
    do_start();
    fetch_load(0); play(10, 4); gap();
    fetch_load(1); play(20, 2); gap();
    fetch_load(2);
    end_done();
    chk("s1_done_count", 32'(done_cnt - d0), 1);

    // Same table with loop: the marker returns to address 0 and note 0 replays.
    d0 = done_cnt;
    loop = 1'b1;
    do_start();
    fetch_load(0); play(10, 4); gap();
    fetch_load(1); play(20, 2); gap();
    fetch_load(2);
    chk("loop_busy", 32'(busy), 1);
    fetch_load(0); play(10, 4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("loop_stop_busy", 32'(busy), 0);
    chk("loop_stop_addr", 32'(rom_addr), 0);
    chk("s2_done_count", 32'(done_cnt - d0), 0);
    loop = 1'b0;

    // Full table without a marker: rest, div=1, div=3, div=2, then wrap.
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h13; mem[3] = 8'h12;
    d0 = done_cnt;
    do_start();
    fetch_load(0); play(10, 0); gap();
    fetch_load(1); play(10, 1); gap();
    fetch_load(2); play(10, 3); gap();
    fetch_load(3); play(10, 2);
    end_done();
    chk("s3_done_count", 32'(done_cnt - d0), 1);

    // start and stop together while idle: stays idle.
    mem[0] = 8'h14; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h00;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 0);
    step();
    chk("startstop_busy2", 32'(busy), 0);

    // stop five cycles into note 1.
    d0 = done_cnt;
    do_start();
    fetch_load(0); play(10, 4); gap();
    fetch_load(1); play(5, 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_ch", 32'(ch_out), 0);
    chk("stop_addr", 32'(rom_addr), 0);
    chk("stop_done", 32'(done), 0);
    step(); step();
    chk("stop_idle_busy", 32'(busy), 0);
    chk("s4_done_count", 32'(done_cnt - d0), 0);

    // Asynchronous reset in the middle of note 1, while ch_out is high.
    d0 = done_cnt;
    do_start();
    fetch_load(0); play(10, 4); gap();
    fetch_load(1); play(3, 2);
    chk("pre_rst_ch", 32'(ch_out), 1);
    chk("pre_rst_addr", 32'(rom_addr), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(rom_addr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_ch", 32'(ch_out), 0);
    step();
    rst = 1'b0;
    step(); step();
    chk("post_rst_busy", 32'(busy), 0);
    chk("s5_done_count", 32'(done_cnt - d0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
